muldiv_unit: RTL

Parametrised iterative multiply/divide unit with architectural HI/LO registers. It extends the single-cycle MIPS core from the 31-instruction set toward the extended set by executing MULT, MULTU, DIV, DIVU, MTHI and MTLO. The core drives operands from the register file (rs, rt), holds its PC while `busy` is high, and reads `hi`/`lo` for MFHI/MFLO.

---
 rtl/muldiv_unit.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide share one 2*WIDTH accumulator.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StSign} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 is_div_q, is_div_d, sq_q, sq_d, sr_q, sr_d;
  logic                 done_q, done_d, dz_q, dz_d;

  logic                 idle, is_mul_op, is_div_op, signed_op, b_zero;
  logic                 accept_calc, accept_dz, accept_mthi, accept_mtlo;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH:0]       mul_sum, div_diff;
  logic [2*WIDTH-1:0]   mul_next, div_next, prod;
  logic [WIDTH-1:0]     quo, rem, quo_s, rem_s;

  assign idle        = (state_q == StIdle);
  assign is_mul_op   = (op[2:1] == 2'b00);
  assign is_div_op   = (op[2:1] == 2'b01);
  assign signed_op   = op[0] & ~op[2];
  assign b_zero      = (b == '0);
  assign accept_calc = idle & start & (is_mul_op | (is_div_op & ~b_zero));
  assign accept_dz   = idle & start & is_div_op & b_zero;
  assign accept_mthi = idle & start & (op == 3'b100);
  assign accept_mtlo = idle & start & (op == 3'b101);

  // Most-negative input maps to itself, which is the correct unsigned magnitude.
  assign abs_a = (signed_op & a[WIDTH-1]) ? -a : a;
  assign abs_b = (signed_op & b[WIDTH-1]) ? -b : b;

  // Multiply: upper half accumulates the multiplicand, lower half holds the multiplier.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q & {WIDTH{acc_q[0]}}};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: upper half is the remainder, lower half shifts dividend out and quotient in.
  assign div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};
  assign div_next = div_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  assign prod  = sq_q ? -acc_q : acc_q;
  assign quo   = acc_q[WIDTH-1:0];
  assign rem   = acc_q[2*WIDTH-1:WIDTH];
  assign quo_s = sq_q ? -quo : quo;
  assign rem_s = sr_q ? -rem : rem;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept_calc) state_d = StCalc;
      StCalc:  if (cnt_q == CntW'(1)) state_d = StSign;
      StSign:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    sq_d     = sq_q;
    sr_d     = sr_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dz_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept_calc) begin
          acc_d    = {{WIDTH{1'b0}}, abs_a};
          opb_d    = abs_b;
          cnt_d    = CntW'(WIDTH);
          is_div_d = op[1];
          sq_d     = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
          sr_d     = signed_op & a[WIDTH-1];
        end
        if (accept_dz) begin
          done_d = 1'b1;
          dz_d   = 1'b1;
        end
        if (accept_mthi) begin
          hi_d   = a;
          done_d = 1'b1;
        end
        if (accept_mtlo) begin
          lo_d   = a;
          done_d = 1'b1;
        end
      end
      StCalc: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q - CntW'(1);
      end
      StSign: begin
        hi_d   = is_div_q ? rem_s : prod[2*WIDTH-1:WIDTH];
        lo_d   = is_div_q ? quo_s : prod[WIDTH-1:0];
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      sq_q     <= 1'b0;
      sr_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      sq_q     <= sq_d;
      sr_q     <= sr_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  always_comb begin
    busy     = (state_q != StIdle);
    done     = done_q;
    div_zero = dz_q;
    hi       = hi_q;
    lo       = lo_q;
  end

endmodule
